// File: rtl/scr1_dmem_resp_ram.sv
// Data-memory responder: word-organised RAM behind the SCR1 dmem handshake,
// with a programmable number of wait cycles between accept and response.

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_memif_pkg;
    typedef enum logic [1:0] {
        SCR1_MEM_CMD_RD    = 2'd0,
        SCR1_MEM_CMD_WR    = 2'd1,
        SCR1_MEM_CMD_ERROR = 2'd2
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'd0,
        SCR1_MEM_WIDTH_HWORD = 2'd1,
        SCR1_MEM_WIDTH_WORD  = 2'd2,
        SCR1_MEM_WIDTH_ERROR = 2'd3
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'd0,
        SCR1_MEM_RESP_RDY_OK = 2'd1,
        SCR1_MEM_RESP_RDY_ER = 2'd2
    } type_scr1_mem_resp_e;
endpackage

module scr1_dmem_resp_ram
    import scr1_memif_pkg::*;
#(
    parameter int unsigned SCR1_RAM_WORDS = 1024,
    parameter int unsigned SCR1_RAM_WAIT  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         dmem_req_ack,
    input  logic                         dmem_req,
    input  type_scr1_mem_cmd_e           dmem_cmd,
    input  type_scr1_mem_width_e         dmem_width,
    input  logic [`SCR1_DMEM_AWIDTH-1:0] dmem_addr,
    input  logic [`SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
    output logic [`SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
    output type_scr1_mem_resp_e          dmem_resp
);

    localparam int unsigned AW = `SCR1_DMEM_AWIDTH;
    localparam int unsigned IW = $clog2(SCR1_RAM_WORDS);
    localparam logic [2:0] WaitCycles = 3'(SCR1_RAM_WAIT);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e               state_q;
    logic [2:0]           cnt_q;
    logic                 err_q;
    type_scr1_mem_cmd_e   cmd_q;
    type_scr1_mem_width_e width_q;
    logic [IW+1:0]        addr_q;
    logic [31:0]          wdata_q;

    logic [31:0] mem [SCR1_RAM_WORDS];

    logic        accept;
    logic        req_err;
    logic        resp_fire;
    logic [3:0]  wr_be;
    logic [31:0] wr_lanes;
    logic [31:0] rd_word;

    assign dmem_req_ack = ~rst & (state_q != StWait);
    assign accept       = dmem_req & dmem_req_ack;
    // A reset landing on the response cycle cancels both the write and the response.
    assign resp_fire    = ~rst & (state_q == StResp);

    always_comb begin
        req_err = 1'b0;
        if (dmem_cmd != SCR1_MEM_CMD_RD && dmem_cmd != SCR1_MEM_CMD_WR) req_err = 1'b1;
        case (dmem_width)
            SCR1_MEM_WIDTH_BYTE:  ;
            SCR1_MEM_WIDTH_HWORD: if (dmem_addr[0]) req_err = 1'b1;
            SCR1_MEM_WIDTH_WORD:  if (dmem_addr[1:0] != 2'b00) req_err = 1'b1;
            default:              req_err = 1'b1;
        endcase
        // Word count is a power of two, so any set bit above the index is out of range.
        if (|dmem_addr[AW-1:IW+2]) req_err = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                StWait: begin
                    if (cnt_q <= 3'd1) state_q <= StResp;
                    if (cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
                end
                default: begin
                    if (accept) begin
                        err_q <= req_err;
                        if (WaitCycles == 3'd0) begin
                            state_q <= StResp;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= WaitCycles;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_q   <= dmem_cmd;
            width_q <= dmem_width;
            addr_q  <= dmem_addr[IW+1:0];
            wdata_q <= dmem_wdata;
        end
    end

    always_comb begin
        wr_be    = 4'b0000;
        wr_lanes = wdata_q;
        case (width_q)
            SCR1_MEM_WIDTH_BYTE: begin
                wr_be    = 4'b0001 << addr_q[1:0];
                wr_lanes = {4{wdata_q[7:0]}};
            end
            SCR1_MEM_WIDTH_HWORD: begin
                wr_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{wdata_q[15:0]}};
            end
            SCR1_MEM_WIDTH_WORD: wr_be = 4'b1111;
            default:             wr_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resp_fire && !err_q && cmd_q == SCR1_MEM_CMD_WR) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[addr_q[IW+1:2]][8*b +: 8] <= wr_lanes[8*b +: 8];
            end
        end
    end

    assign rd_word = mem[addr_q[IW+1:2]];

    always_comb begin
        dmem_resp  = SCR1_MEM_RESP_NOTRDY;
        dmem_rdata = '0;
        if (resp_fire) begin
            dmem_resp = err_q ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
            if (!err_q && cmd_q == SCR1_MEM_CMD_RD) begin
                dmem_rdata = rd_word >> {addr_q[1:0], 3'b000};
            end
        end
    end

endmodule

// File: tb/tb_scr1_dmem_resp_ram.sv
// Bench for scr1_dmem_resp_ram: a zero-wait instance and a three-wait instance,
// each checked by a queue-based scoreboard plus handshake timing checks.

module tb_scr1_dmem_resp_ram;
    import scr1_memif_pkg::*;

    localparam int unsigned Words = 16;

    typedef struct {
        type_scr1_mem_resp_e resp;
        logic [31:0]         rdata;
        string               name;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst0, ack0, req0;
    type_scr1_mem_cmd_e   cmd0;
    type_scr1_mem_width_e width0;
    logic [31:0]          addr0, wdata0, rdata0;
    type_scr1_mem_resp_e  resp0;

    logic                 rst3, ack3, req3;
    type_scr1_mem_cmd_e   cmd3;
    type_scr1_mem_width_e width3;
    logic [31:0]          addr3, wdata3, rdata3;
    type_scr1_mem_resp_e  resp3;

    exp_t q0[$];
    exp_t q3[$];
    int   checks   = 0;
    int   failures = 0;

    scr1_dmem_resp_ram #(.SCR1_RAM_WORDS(Words), .SCR1_RAM_WAIT(0)) dut0 (
        .clk(clk), .rst(rst0), .dmem_req_ack(ack0), .dmem_req(req0), .dmem_cmd(cmd0),
        .dmem_width(width0), .dmem_addr(addr0), .dmem_wdata(wdata0), .dmem_rdata(rdata0),
        .dmem_resp(resp0)
    );

    scr1_dmem_resp_ram #(.SCR1_RAM_WORDS(Words), .SCR1_RAM_WAIT(3)) dut3 (
        .clk(clk), .rst(rst3), .dmem_req_ack(ack3), .dmem_req(req3), .dmem_cmd(cmd3),
        .dmem_width(width3), .dmem_addr(addr3), .dmem_wdata(wdata3), .dmem_rdata(rdata3),
        .dmem_resp(resp3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: pop on any ready response, otherwise rdata must stay zero.
    always @(negedge clk) begin
        exp_t e;
        if (resp0 != SCR1_MEM_RESP_NOTRDY) begin
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut0_unexpected_resp: got resp %0d, expected none", resp0);
            end else begin
                e = q0.pop_front();
                check({e.name, "_resp"}, 32'(resp0), 32'(e.resp));
                check({e.name, "_rdata"}, rdata0, e.rdata);
            end
        end else begin
            check("dut0_idle_rdata", rdata0, 32'h0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (resp3 != SCR1_MEM_RESP_NOTRDY) begin
            if (q3.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut3_unexpected_resp: got resp %0d, expected none", resp3);
            end else begin
                e = q3.pop_front();
                check({e.name, "_resp"}, 32'(resp3), 32'(e.resp));
                check({e.name, "_rdata"}, rdata3, e.rdata);
            end
        end else begin
            check("dut3_idle_rdata", rdata3, 32'h0);
        end
    end

    // Zero-wait: hold the request for one edge; the response must be up in the next cycle.
    task automatic issue0(input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                          input logic [31:0] a, input logic [31:0] d,
                          input type_scr1_mem_resp_e er, input logic [31:0] ed,
                          input string name);
        exp_t e;
        e.resp  = er;
        e.rdata = ed;
        e.name  = name;
        q0.push_back(e);
        req0 = 1'b1; cmd0 = c; width0 = w; addr0 = a; wdata0 = d;
        @(posedge clk); #1;
        check({name, "_latency"}, 32'(resp0 != SCR1_MEM_RESP_NOTRDY), 32'd1);
    endtask

    // Three-wait: accept at cycle N, ack/resp low on N+1..N+3, response on N+4.
    task automatic issue3(input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                          input logic [31:0] a, input logic [31:0] d,
                          input type_scr1_mem_resp_e er, input logic [31:0] ed,
                          input string name);
        exp_t e;
        e.resp  = er;
        e.rdata = ed;
        e.name  = name;
        q3.push_back(e);
        req3 = 1'b1; cmd3 = c; width3 = w; addr3 = a; wdata3 = d;
        check({name, "_ack_idle"}, 32'(ack3), 32'd1);
        @(posedge clk); #1;
        req3 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check({name, "_wait_ack"}, 32'(ack3), 32'd0);
            check({name, "_wait_resp"}, 32'(resp3), 32'(SCR1_MEM_RESP_NOTRDY));
        end
        @(negedge clk);
        check({name, "_resp_cycle"}, 32'(resp3), 32'(er));
        @(posedge clk); #1;
    endtask

    initial begin
        rst0 = 1'b1; req0 = 1'b0; cmd0 = SCR1_MEM_CMD_RD; width0 = SCR1_MEM_WIDTH_WORD;
        addr0 = '0; wdata0 = '0;
        rst3 = 1'b1; req3 = 1'b0; cmd3 = SCR1_MEM_CMD_RD; width3 = SCR1_MEM_WIDTH_WORD;
        addr3 = '0; wdata3 = '0;
        repeat (2) @(posedge clk);
        #1;
        req0 = 1'b1;
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_resp0", 32'(resp0), 32'(SCR1_MEM_RESP_NOTRDY));
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_ack3", 32'(ack3), 32'd0);
        req0 = 1'b0;
        rst0 = 1'b0;
        #1;
        check("post_rst_ack0", 32'(ack0), 32'd1);
        @(posedge clk); #1;

        issue0(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10, 32'hDEADBEEF,
               SCR1_MEM_RESP_RDY_OK, 32'h0, "b2b_wr");
        issue0(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0,
               SCR1_MEM_RESP_RDY_OK, 32'hDEADBEEF, "b2b_rd");
        issue0(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h11223344,
               SCR1_MEM_RESP_RDY_OK, 32'h0, "wr_base");
        issue0(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h13, 32'h000000A5,
               SCR1_MEM_RESP_RDY_OK, 32'h0, "wr_byte");
        issue0(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0,
               SCR1_MEM_RESP_RDY_OK, 32'hA5223344, "rd_after_byte");
        issue0(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h12, 32'h0,
               SCR1_MEM_RESP_RDY_OK, 32'h0000A522, "rd_hword");
        issue0(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h11, 32'h0,
               SCR1_MEM_RESP_RDY_OK, 32'h00A52233, "rd_byte_shift");
        issue0(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h00, 32'h55AA55AA,
               SCR1_MEM_RESP_RDY_OK, 32'h0, "wr_word0");
        issue0(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h11, 32'h0000FFFF,
               SCR1_MEM_RESP_RDY_ER, 32'h0, "err_hw_misalign");
        issue0(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h40, 32'hFFFFFFFF,
               SCR1_MEM_RESP_RDY_ER, 32'h0, "err_wr_range");
        issue0(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h40, 32'h0,
               SCR1_MEM_RESP_RDY_ER, 32'h0, "err_rd_range");
        issue0(SCR1_MEM_CMD_ERROR, SCR1_MEM_WIDTH_WORD, 32'h10, 32'hFFFFFFFF,
               SCR1_MEM_RESP_RDY_ER, 32'h0, "err_cmd");
        issue0(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_ERROR, 32'h10, 32'hFFFFFFFF,
               SCR1_MEM_RESP_RDY_ER, 32'h0, "err_width");
        issue0(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h12, 32'hFFFFFFFF,
               SCR1_MEM_RESP_RDY_ER, 32'h0, "err_word_misalign");
        issue0(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0,
               SCR1_MEM_RESP_RDY_OK, 32'hA5223344, "rd_after_errors");
        issue0(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h00, 32'h0,
               SCR1_MEM_RESP_RDY_OK, 32'h55AA55AA, "rd_word0_intact");
        issue0(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h14, 32'h01020304,
               SCR1_MEM_RESP_RDY_OK, 32'h0, "wr_w5");
        issue0(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h16, 32'h0000BEEF,
               SCR1_MEM_RESP_RDY_OK, 32'h0, "wr_hw_hi");
        issue0(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h14, 32'h00000077,
               SCR1_MEM_RESP_RDY_OK, 32'h0, "wr_byte_lo");
        issue0(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h14, 32'h0,
               SCR1_MEM_RESP_RDY_OK, 32'hBEEF0377, "rd_merge");

        // Field changes without a request must not write or respond.
        req0 = 1'b0;
        cmd0 = SCR1_MEM_CMD_WR; width0 = SCR1_MEM_WIDTH_WORD; addr0 = 32'h10; wdata0 = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        issue0(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0,
               SCR1_MEM_RESP_RDY_OK, 32'hA5223344, "rd_no_req_effect");
        req0 = 1'b0;

        rst3 = 1'b0;
        @(posedge clk); #1;
        issue3(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h20, 32'hCAFEF00D,
               SCR1_MEM_RESP_RDY_OK, 32'h0, "w3_wr");
        issue3(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h20, 32'h0,
               SCR1_MEM_RESP_RDY_OK, 32'hCAFEF00D, "w3_rd");
        issue3(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h22, 32'h0,
               SCR1_MEM_RESP_RDY_ER, 32'h0, "w3_err");

        // Reset during the second wait cycle drops the write and its response.
        req3 = 1'b1; cmd3 = SCR1_MEM_CMD_WR; width3 = SCR1_MEM_WIDTH_WORD;
        addr3 = 32'h20; wdata3 = 32'h12345678;
        @(posedge clk); #1;
        req3 = 1'b0;
        @(posedge clk); #1;
        rst3 = 1'b1;
        @(negedge clk);
        check("w3_rst_ack", 32'(ack3), 32'd0);
        check("w3_rst_resp", 32'(resp3), 32'(SCR1_MEM_RESP_NOTRDY));
        @(posedge clk); #1;
        rst3 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        issue3(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h20, 32'h0,
               SCR1_MEM_RESP_RDY_OK, 32'hCAFEF00D, "w3_rd_after_rst");

        for (int i = 0; i < 10 && (q0.size() != 0 || q3.size() != 0); i++) @(posedge clk);
        if (q0.size() != 0 || q3.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d/%0d responses outstanding, expected 0/0",
                     q0.size(), q3.size());
        end
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
